// File: rtl/vga_char_pkg.sv
// Shared constants, stage-1 payload type and the 8x16 hex font for the character banner.
package vga_char_pkg;

    localparam int unsigned H_VALID  = 640;
    localparam int unsigned V_VALID  = 480;
    localparam int unsigned GLYPH_W  = 8;
    localparam int unsigned GLYPH_H  = 16;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned COLOR_W  = 16;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned ROM_AW   = 8;

    localparam logic [COLOR_W-1:0] RGB565_BLACK   = 16'h0000;
    localparam logic [COLOR_W-1:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [COLOR_W-1:0] RGB565_RED     = 16'hF800;
    localparam logic [COLOR_W-1:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [COLOR_W-1:0] RGB565_BLUE    = 16'h001F;
    localparam logic [COLOR_W-1:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [COLOR_W-1:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [COLOR_W-1:0] RGB565_MAGENTA = 16'hF81F;

    // Stage-1 pipeline payload carried to the pixel output stage.
    typedef struct packed {
        logic                 in_area;
        logic [ROM_AW-1:0]    rom_addr;
        logic [2:0]           bit_sel;
        logic [COLOR_W-1:0]   fg;
    } stage1_t;

    // Glyphs '0'-'9','A'-'F'; 16 rows each, MSB is the leftmost pixel.
    localparam logic [7:0] HEX_FONT [0:255] = '{
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE, 8'hF6, 8'hE6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC6, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'h06, 8'h06, 8'h3C, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFE, 8'hC0, 8'hC0, 8'hC0, 8'hFC, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h38, 8'h60, 8'hC0, 8'hC0, 8'hFC, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFE, 8'hC6, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'h7E, 8'h06, 8'h06, 8'h06, 8'h0C, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h3C, 8'h66, 8'hC2, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC2, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hF8, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h6C, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFE, 8'h66, 8'h62, 8'h68, 8'h78, 8'h68, 8'h60, 8'h62, 8'h66, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFE, 8'h66, 8'h62, 8'h68, 8'h78, 8'h68, 8'h60, 8'h60, 8'h60, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/vga_glyph_rom.sv
// Combinational 256x8 glyph lookup: address = code*16 + row.
module vga_glyph_rom (
    input  logic [7:0] rom_addr,
    output logic [7:0] rom_data_c
);
    import vga_char_pkg::*;

    // Plain table read; synthesises to a small ROM / LUT tree.
    always_comb begin
        rom_data_c = HEX_FONT[rom_addr];
    end

endmodule

// File: rtl/vga_char_banner.sv
// Scrolling hex-character banner overlay with a 2-stage pixel pipeline.
// Optional blink feature enabled by defining VGA_CHAR_BANNER_BLINK_EN.
module vga_char_banner #(
    parameter int unsigned NUM_CHARS   = 3,
    parameter int unsigned SCALE       = 4,
    parameter int unsigned START_X     = 324,
    parameter int unsigned START_Y     = 208,
    parameter logic [15:0] BG_COLOR    = 16'hFFFF,
    parameter int unsigned SCROLL_DIV  = 2,
    parameter int unsigned SCROLL_STEP = 1
`ifdef VGA_CHAR_BANNER_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 30
`endif
) (
    input  logic                   vga_clk,
    input  logic                   sys_rst_n,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic [NUM_CHARS*4-1:0] char_codes,
    input  logic [15:0]            fg_color,
    input  logic                   scroll_en,
    output logic [15:0]            pix_data,
    output logic                   frame_end
);
    import vga_char_pkg::*;

    localparam int unsigned SCALE_LOG2  = $clog2(SCALE);
    localparam int unsigned TOTAL_WIDTH = NUM_CHARS * GLYPH_W * SCALE;
    localparam int unsigned BANNER_H    = GLYPH_H * SCALE;
    localparam logic [10:0] H_VALID_W   = 11'(H_VALID);
    localparam logic [10:0] START_X_W   = 11'(START_X % H_VALID);
    localparam logic [10:0] START_Y_W   = 11'(START_Y);
    localparam logic [10:0] Y_END_W     = 11'(START_Y + BANNER_H);
    localparam logic [10:0] TOTAL_W     = 11'(TOTAL_WIDTH);
    localparam logic [10:0] STEP_W      = 11'(SCROLL_STEP);
    localparam logic [7:0]  DIV_LAST    = 8'(SCROLL_DIV - 1);
    localparam logic [9:0]  X_LAST      = 10'(H_VALID - 1);
    localparam logic [9:0]  Y_LAST      = 10'(V_VALID - 1);

    if (SCALE != 1 && SCALE != 2 && SCALE != 4 && SCALE != 8) begin : g_bad_scale
        $error("SCALE must be 1, 2, 4 or 8");
    end

    logic [9:0]  x_ofs;
    logic [7:0]  fcnt;
    logic        blink_vis;
    stage1_t     s1_q;

    logic [10:0] pos_sum_c;
    logic [10:0] pos_c;
    logic [10:0] rel_x_c;
    logic [10:0] y_ofs_c;
    logic [10:0] char_idx_c;
    logic [3:0]  code_c;
    logic [3:0]  row_c;
    logic [2:0]  bit_sel_c;
    logic        in_area_c;
    logic [10:0] x_ofs_sum_c;
    logic [9:0]  x_ofs_next_c;
    logic [7:0]  rom_data_c;

    // Banner position, wrapped relative column and glyph address decode.
    always_comb begin
        pos_sum_c  = START_X_W + {1'b0, x_ofs};
        pos_c      = (pos_sum_c >= H_VALID_W) ? (pos_sum_c - H_VALID_W) : pos_sum_c;
        rel_x_c    = ({1'b0, pix_x} >= pos_c) ? ({1'b0, pix_x} - pos_c)
                                              : ({1'b0, pix_x} + H_VALID_W - pos_c);
        y_ofs_c    = {1'b0, pix_y} - START_Y_W;
        in_area_c  = (rel_x_c < TOTAL_W) && ({1'b0, pix_y} >= START_Y_W)
                     && ({1'b0, pix_y} < Y_END_W) && blink_vis;
        char_idx_c = rel_x_c >> (3 + SCALE_LOG2);
        bit_sel_c  = 3'(rel_x_c >> SCALE_LOG2);
        row_c      = 4'(y_ofs_c >> SCALE_LOG2);
        code_c     = '0;
        for (int unsigned i = 0; i < NUM_CHARS; i++) begin
            if (char_idx_c == 11'(i)) begin
                code_c = char_codes[i*4 +: 4];
            end
        end
    end

    // Next scroll offset, kept within one line width.
    always_comb begin
        x_ofs_sum_c  = {1'b0, x_ofs} + STEP_W;
        x_ofs_next_c = (x_ofs_sum_c >= H_VALID_W) ? 10'(x_ofs_sum_c - H_VALID_W)
                                                  : 10'(x_ofs_sum_c);
    end

    vga_glyph_rom u_rom (
        .rom_addr   (s1_q.rom_addr),
        .rom_data_c (rom_data_c)
    );

    // Stage 1: capture area flag, ROM address, bit select and colour.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q.in_area  <= in_area_c;
            s1_q.rom_addr <= {code_c, row_c};
            s1_q.bit_sel  <= bit_sel_c;
            s1_q.fg       <= fg_color;
        end
    end

    // Stage 2: pixel colour and end-of-frame pulse.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data  <= BG_COLOR;
            frame_end <= 1'b0;
        end else begin
            pix_data  <= (s1_q.in_area && rom_data_c[3'd7 - s1_q.bit_sel]) ? s1_q.fg : BG_COLOR;
            frame_end <= (pix_x == X_LAST) && (pix_y == Y_LAST);
        end
    end

    // Frame divider and scroll offset; both advance only on frame_end.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fcnt  <= '0;
            x_ofs <= '0;
        end else if (frame_end) begin
            if (fcnt == DIV_LAST) begin
                fcnt <= '0;
                if (scroll_en) begin
                    x_ofs <= x_ofs_next_c;
                end
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end

`ifdef VGA_CHAR_BANNER_BLINK_EN
    localparam int unsigned BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] bcnt;

    // Blink counter: flip visibility every BLINK_FRAMES frames.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bcnt      <= '0;
            blink_vis <= 1'b1;
        end else if (frame_end) begin
            if (bcnt == BLINK_LAST) begin
                bcnt      <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end
`else
    assign blink_vis = 1'b1;
`endif

endmodule

// File: tb/tb_vga_char_banner.sv
// Randomised self-checking bench for vga_char_banner against a frame-level reference model.
module tb_vga_char_banner;
    import vga_char_pkg::*;

    localparam int unsigned NUM_CHARS   = 3;
    localparam int unsigned SCALE       = 4;
    localparam int unsigned START_X     = 324;
    localparam int unsigned START_Y     = 208;
    localparam int unsigned SCROLL_DIV  = 2;
    localparam int unsigned SCROLL_STEP = 1;
    localparam logic [15:0] BG          = 16'hFFFF;
    localparam int          TW          = NUM_CHARS * 8 * SCALE;
`ifdef VGA_CHAR_BANNER_BLINK_EN
    localparam int unsigned BLINK_FRAMES = 2;
    localparam logic [15:0] EXP_AFTER_2  = 16'hFFFF;
`else
    localparam logic [15:0] EXP_AFTER_2  = 16'h07E0;
`endif

    logic                   vga_clk;
    logic                   sys_rst_n;
    logic [9:0]             pix_x;
    logic [9:0]             pix_y;
    logic [NUM_CHARS*4-1:0] char_codes;
    logic [15:0]            fg_color;
    logic                   scroll_en;
    logic [15:0]            pix_data;
    logic                   frame_end;

    vga_char_banner #(
        .NUM_CHARS   (NUM_CHARS),
        .SCALE       (SCALE),
        .START_X     (START_X),
        .START_Y     (START_Y),
        .BG_COLOR    (BG),
        .SCROLL_DIV  (SCROLL_DIV),
        .SCROLL_STEP (SCROLL_STEP)
`ifdef VGA_CHAR_BANNER_BLINK_EN
        ,
        .BLINK_FRAMES(BLINK_FRAMES)
`endif
    ) dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .char_codes (char_codes),
        .fg_color   (fg_color),
        .scroll_en  (scroll_en),
        .pix_data   (pix_data),
        .frame_end  (frame_end)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int total = 0;
    int bad   = 0;

    // Stimulus values applied on the next cycle call.
    logic [11:0] cur_codes = 12'h000;
    logic [15:0] cur_fg    = 16'h0000;
    logic        cur_sen   = 1'b0;

    // Reference model state.
    int          m_xofs   = 0;
    int          m_frames = 0;
    bit          m_vis    = 1'b1;
    bit          m_prev_last = 1'b0;
    logic [15:0] e_pix1 = 16'hFFFF;
    logic [15:0] e_pix2 = 16'hFFFF;
    bit          e_fe1  = 1'b0;

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic chkint(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected colour of one pixel from the banner geometry rules.
    function automatic logic [15:0] model_pix(input int px, input int py, input logic [11:0] codes,
                                              input logic [15:0] fg, input int xofs, input bit vis);
        int pos, rel, ch, col, row, code;
        logic [7:0] glyph_row;
        pos = (START_X + xofs) % 640;
        rel = (px - pos + 640) % 640;
        if (!vis || rel >= TW || py < int'(START_Y) || py >= int'(START_Y + 16 * SCALE))
            return BG;
        ch   = rel / (8 * SCALE);
        col  = (rel / SCALE) % 8;
        row  = (py - int'(START_Y)) / SCALE;
        code = int'((codes >> (4 * ch)) & 12'hF);
        glyph_row = HEX_FONT[code * 16 + row];
        return glyph_row[7 - col] ? fg : BG;
    endfunction

    // One pixel cycle: compare outputs due now, drive new inputs, advance the model.
    task automatic cycle(input int x, input int y, input bit rst_lo);
        logic [15:0] e;
        bit last;
        @(negedge vga_clk);
        chk16("pix_data", pix_data, e_pix2);
        chk16("frame_end", {15'd0, frame_end}, {15'd0, e_fe1});
        pix_x      = 10'(x);
        pix_y      = 10'(y);
        char_codes = cur_codes;
        fg_color   = cur_fg;
        scroll_en  = cur_sen;
        if (rst_lo) begin
            sys_rst_n = 1'b0;
            #1;
            chk16("rst_pix_now", pix_data, BG);
            chk16("rst_fe_now", {15'd0, frame_end}, 16'd0);
            m_xofs = 0; m_frames = 0; m_vis = 1'b1; m_prev_last = 1'b0;
            e_pix1 = BG; e_pix2 = BG; e_fe1 = 1'b0;
        end else begin
            sys_rst_n = 1'b1;
            e = model_pix(x, y, cur_codes, cur_fg, m_xofs, m_vis);
            if (m_prev_last) begin
                m_frames++;
                if (m_frames % SCROLL_DIV == 0 && cur_sen)
                    m_xofs = (m_xofs + SCROLL_STEP) % 640;
`ifdef VGA_CHAR_BANNER_BLINK_EN
                if (m_frames % BLINK_FRAMES == 0)
                    m_vis = !m_vis;
`endif
            end
            last = (x == 639 && y == 479);
            m_prev_last = last;
            e_pix2 = e_pix1;
            e_pix1 = e;
            e_fe1  = last;
        end
    endtask

    // Random pixel near the banner rows, never the last pixel of the frame.
    task automatic rnd_banner_cycle();
        cycle(int'($urandom_range(0, 639)), int'($urandom_range(START_Y - 4, START_Y + 16 * SCALE + 3)), 1'b0);
    endtask

    task automatic frame_pulse();
        cycle(639, 479, 1'b0);
        rnd_banner_cycle();
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        char_codes = '0;
        fg_color   = '0;
        scroll_en  = 1'b0;

        // Reset held while sweeping coordinates.
        repeat (20) cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
        chkint("x_ofs_in_reset", int'(dut.x_ofs), 0);

        // Glyph hit and just past the banner end.
        cur_codes = 12'hD0D; cur_fg = 16'h0000; cur_sen = 1'b0;
        cycle(332, 224, 1'b0);
        cycle(516, 224, 1'b0);
        cycle(100, 100, 1'b0);
        chk16("glyph_hit_D", pix_data, 16'h0000);
        cycle(100, 100, 1'b0);
        chk16("past_banner", pix_data, 16'hFFFF);
        repeat (40) rnd_banner_cycle();

        // Scroll by one after two frames.
        cur_sen = 1'b1; cur_fg = 16'h07E0;
        frame_pulse();
        frame_pulse();
        rnd_banner_cycle();
        chkint("x_ofs_after_2", int'(dut.x_ofs), 1);
        cycle(333, 224, 1'b0);
        cycle(10, 10, 1'b0);
        cycle(10, 10, 1'b0);
        chk16("scrolled_pixel", pix_data, EXP_AFTER_2);
        frame_pulse();
        frame_pulse();
        rnd_banner_cycle();
        chkint("x_ofs_after_4", int'(dut.x_ofs), 2);
        cycle(333, 224, 1'b0);
        cycle(10, 10, 1'b0);
        cycle(10, 10, 1'b0);
        chk16("frame4_pixel", pix_data, 16'h07E0);

        // Advance to x_ofs = 300 (600 frames), banner start wraps to 624.
        repeat (596) begin
            if ($urandom_range(0, 3) == 0) cur_codes = 12'($urandom);
            if ($urandom_range(0, 3) == 0) cur_fg = 16'($urandom);
            frame_pulse();
        end
        rnd_banner_cycle();
        chkint("x_ofs_300", int'(dut.x_ofs), 300);
        cur_codes = 12'h00A; cur_fg = 16'hF800;
        cycle(0, 224, 1'b0);
        cycle(10, 10, 1'b0);
        cycle(10, 10, 1'b0);
        chk16("wrap_left_edge", pix_data, 16'hF800);
        repeat (60) rnd_banner_cycle();

        // Hold for ten frames while the divider keeps counting.
        cur_sen = 1'b0;
        repeat (10) frame_pulse();
        rnd_banner_cycle();
        chkint("x_ofs_hold", int'(dut.x_ofs), 300);
        chkint("fcnt_hold", int'(dut.fcnt), 0);

        // Scroll across the 639 -> 0 boundary.
        cur_sen = 1'b1;
        repeat (700) begin
            if ($urandom_range(0, 4) == 0) cur_codes = 12'($urandom);
            frame_pulse();
        end
        rnd_banner_cycle();
        chkint("x_ofs_wrapped", int'(dut.x_ofs), 10);

        // Fully random traffic including scroll enable flips.
        repeat (1500) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 19) == 0) cur_codes = 12'($urandom);
            if ($urandom_range(0, 9) == 0) cur_fg = 16'($urandom);
            if ($urandom_range(0, 29) == 0) cur_sen = !cur_sen;
            if (r < 8) cycle(639, 479, 1'b0);
            else if (r < 70) rnd_banner_cycle();
            else cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b0);
        end
        rnd_banner_cycle();
        rnd_banner_cycle();
        chkint("x_ofs_model", int'(dut.x_ofs), m_xofs);

        // Reset asserted mid-frame with a glyph pixel in flight.
        cur_codes = 12'hD0D; cur_fg = 16'h0000;
        cycle(332 + m_xofs >= 640 ? 332 + m_xofs - 640 : 332 + m_xofs, 224, 1'b0);
        cycle(20, 20, 1'b1);
        repeat (8) cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1);
        chkint("x_ofs_mid_reset", int'(dut.x_ofs), 0);
        cycle(332, 224, 1'b0);
        cycle(10, 10, 1'b0);
        chk16("first_after_rst_bg", pix_data, BG);
        cycle(10, 10, 1'b0);
        chk16("first_after_rst_hit", pix_data, 16'h0000);
        repeat (50) rnd_banner_cycle();
        cycle(10, 10, 1'b0);
        cycle(10, 10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_char_banner.md
VGA_CHAR_BANNER -- requirements
Module: vga_char_banner

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 3: glyph count, 1..8.
REQ-002 SHALL have parameter SCALE, default 4: pixel magnification; only 1, 2, 4 or 8 are legal.
REQ-003 SHALL have parameter START_X, default 324: left edge of the banner at scroll offset 0.
REQ-004 SHALL have parameter START_Y, default 208: top edge of the banner.
REQ-005 SHALL have parameter BG_COLOR, default 16'hFFFF: background colour (RGB565).
REQ-006 SHALL have parameter SCROLL_DIV, default 2: frames per scroll step, 1..255.
REQ-007 SHALL have parameter SCROLL_STEP, default 1: pixels moved per step, 1..63.
REQ-008 SHALL have input vga_clk, 1 bit: pixel clock.
REQ-009 SHALL have input sys_rst_n, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have input pix_x, 10 bits: current active column, 0..639.
REQ-011 SHALL have input pix_y, 10 bits: current active row, 0..479.
REQ-012 SHALL have input char_codes, NUM_CHARS*4 bits: glyph codes; bits [3:0] select the leftmost glyph.
REQ-013 SHALL have input fg_color, 16 bits: glyph colour, sampled in pipeline stage 1.
REQ-014 SHALL have input scroll_en, 1 bit: 1 = banner scrolls right, 0 = banner holds position.
REQ-015 SHALL have output pix_data, 16 bits, registered: RGB565 pixel.
REQ-016 SHALL have output frame_end, 1 bit, registered: one-cycle pulse on the last active pixel.

Function
REQ-017 Glyphs SHALL be 8x16 cells scaled by SCALE: each glyph is 8*SCALE wide and 16*SCALE high; TOTAL_WIDTH = NUM_CHARS*8*SCALE.
REQ-018 Banner x position SHALL be pos = (START_X + x_ofs) mod 640.
REQ-019 rel_x SHALL be pix_x - pos when pix_x >= pos, otherwise pix_x + 640 - pos; the banner therefore wraps from the right edge to the left edge.
REQ-020 A pixel SHALL be inside the banner iff rel_x < TOTAL_WIDTH and START_Y <= pix_y < START_Y + 16*SCALE.
REQ-021 Address decode SHALL be: char index = rel_x >> (3+log2 SCALE); column = (rel_x >> log2 SCALE) & 7; row = (pix_y - START_Y) >> log2 SCALE.
REQ-022 ROM address SHALL be code*16 + row; the ROM byte MSB is the leftmost pixel.
REQ-023 Pipeline: stage 1 SHALL register in_area, rom_addr, bit_sel and fg_color; stage 2 SHALL register pix_data. Latency is exactly 2 vga_clk cycles from pix_x/pix_y to pix_data.
REQ-024 pix_data SHALL be fg when in_area and the glyph bit = 1 (and blink is visible, see REQ-033); otherwise it SHALL be BG_COLOR.
REQ-025 frame_end SHALL be asserted for one cycle on the cycle after pix_x == 639 && pix_y == 479 is sampled.
REQ-026 The frame counter fcnt SHALL count frame_end pulses in the range 0..SCROLL_DIV-1 and then wrap to 0.
REQ-027 On the fcnt wrap with scroll_en = 1, x_ofs SHALL become x_ofs + SCROLL_STEP, minus 640 if the sum is >= 640.
REQ-028 x_ofs SHALL be a 10-bit value, always in the range 0..639.
REQ-029 With scroll_en = 0, x_ofs SHALL hold; fcnt SHALL keep counting.
REQ-030 x_ofs SHALL update only on a frame_end cycle, so no frame shows a mid-frame shift.
REQ-031 A change on char_codes SHALL take effect for the pixel sampled 2 cycles later; no frame buffering is applied.

Reset
REQ-032 While sys_rst_n = 0: pix_data = BG_COLOR, frame_end = 0, x_ofs = 0, fcnt = 0, all pipeline registers = 0, blink state = visible. Reset asserted mid-frame SHALL take effect immediately, and the first pixel after release SHALL follow the normal 2-cycle latency.

Configuration
REQ-033 Defining macro VGA_CHAR_BANNER_BLINK_EN SHALL add parameter BLINK_FRAMES (default 30) and a blink counter that toggles the visible state every BLINK_FRAMES frame_end pulses; while not visible, every banner pixel SHALL be BG_COLOR.
REQ-034 Without VGA_CHAR_BANNER_BLINK_EN, glyphs SHALL always be visible and no blink counter SHALL be synthesised.

Structure
REQ-035 Package vga_char_pkg SHALL hold H_VALID = 640, V_VALID = 480, the RGB565 colour constants, GLYPH_W = 8, GLYPH_H = 16, and the 256-byte hex-font table (codes 0x0-0xF = characters '0'-'9', 'A'-'F').
REQ-036 Sub-module vga_glyph_rom SHALL be the combinational 256x8 lookup indexed by rom_addr.
REQ-037 Scroll logic, blink logic, pipeline and pix_data SHALL be implemented in vga_char_banner.

Verification
REQ-038 Reset test: hold sys_rst_n = 0 while sweeping pix_x/pix_y -> pix_data == 16'hFFFF and frame_end == 0 throughout.
REQ-039 Glyph hit: defaults, char_codes = 12'hD0D, fg_color = 0, pixel (332, 224), i.e. char 0 row 4 col 2 with bit 1 in 'D' -> pix_data == 16'h0000 exactly 2 cycles later; pixel (516, 224) (rel_x = 192) -> 16'hFFFF.
REQ-040 Scroll: scroll_en = 1, SCROLL_DIV = 2 -> after 2 frame_end pulses x_ofs == 1 and banner pixel (333, 224) == fg.
REQ-041 Wrap: force x_ofs = 300, SCROLL_STEP = 16 -> pos = 624; pixel (0, 224) has rel_x = 16 and shows glyph 0 column 4.
REQ-042 Hold: scroll_en = 0 for 10 frames -> x_ofs unchanged.
REQ-043 Blink (macro defined, BLINK_FRAMES = 2): frames 2-3 show the banner as all BG_COLOR; frames 4-5 show it restored.
